pamac_slice_accumulator: RTL and testbench

//  Bit-serial precision-adjustable MAC engine for one FoFIR PE.
//  - Accepts one weight/activation pair per operation.
//  - Walks the activation in 2-bit slices, one slice per cycle, LSB slice first.
//  - Each cycle: forms weight*digit, sign-extends it to 16 bits, shifts it left by 2*k,
//    and adds it into a 32-bit accumulator.
//  - Cycle count equals the requested activation precision, so low precision costs fewer cycles.

---
 rtl/pamac_slice_accumulator_pkg.sv | 34 +++
 rtl/pamac_slice_accumulator_if.sv | 40 ++++
 rtl/pamac_slice_accumulator_pp_gen.sv | 28 ++
 rtl/pamac_slice_accumulator.sv | 127 ++++++++++++
 tb/tb_pamac_slice_accumulator.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pamac_slice_accumulator_pkg.sv
// Shared types, constants and the slice-digit decoder for the PAMAC
// bit-serial multiply-accumulate engine.
package pamac_pkg;

    localparam int SLICE_W     = 2;
    localparam int MAX_SLICES  = 8;
    localparam int ACC_W       = 32;
    localparam int PP_W        = 16;
    localparam int SLICE_IDX_W = 3;
    localparam int ACT_W       = SLICE_W * MAX_SLICES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pamac_state_t;

    // Extracts slice k of the activation as a radix-4 digit. Lower slices are
    // unsigned (0..3); the top slice carries the sign bit and reads as -2..1.
    function automatic logic signed [SLICE_W:0] digit_of(
        input logic [ACT_W-1:0]       act,
        input logic [SLICE_IDX_W-1:0] k,
        input logic                   is_top
    );
        logic [SLICE_W-1:0] bits;
        bits = act[{k, 1'b0} +: SLICE_W];
        if (is_top) begin
            digit_of = $signed({bits[SLICE_W-1], bits});
        end else begin
            digit_of = $signed({1'b0, bits});
        end
    endfunction

endpackage

// File: rtl/pamac_slice_accumulator_if.sv
// Operand / result handshake bundle for the PAMAC engine. The master side
// supplies operand pairs and consumes results; the slave side is the engine.
interface pamac_slice_accumulator_if #(
    parameter int WGT_W = 8,
    parameter int ACT_W = 16,
    parameter int ACC_W = 32
) ();

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WGT_W-1:0] in_weight;
    logic [ACT_W-1:0]        in_act;
    logic [2:0]              in_nslices;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output in_valid,
        output in_weight,
        output in_act,
        output in_nslices,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_weight,
        input  in_act,
        input  in_nslices,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );

endinterface

// File: rtl/pamac_slice_accumulator_pp_gen.sv
// Partial-product generator: weight times one radix-4 digit, widened to
// 16 bits, sign-extended to the accumulator width and aligned by 2*k.
module pamac_pp_gen #(
    parameter int WGT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic signed [WGT_W-1:0] weight,
    input  logic signed [2:0]       digit,
    input  logic [2:0]              k,
    output logic signed [ACC_W-1:0] pp
);
    import pamac_pkg::*;

    logic signed [PP_W-1:0]  w_ext;
    logic signed [PP_W-1:0]  d_ext;
    logic signed [PP_W-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;

    // Multiply at 16 bits (product never exceeds 10 bits), then widen and shift.
    always_comb begin
        w_ext    = {{(PP_W-WGT_W){weight[WGT_W-1]}}, weight};
        d_ext    = {{(PP_W-3){digit[2]}}, digit};
        prod     = w_ext * d_ext;
        prod_ext = {{(ACC_W-PP_W){prod[PP_W-1]}}, prod};
        pp       = prod_ext <<< {k, 1'b0};
    end

endmodule

// File: rtl/pamac_slice_accumulator.sv
// Bit-serial precision-adjustable MAC: consumes the activation two bits per
// cycle, LSB slice first, so an n-slice activation costs n RUN cycles.
module pamac_slice_accumulator #(
    parameter int WGT_W      = 8,
    parameter int ACT_W      = 16,
    parameter int ACC_W      = 32,
    parameter int MAX_SLICES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pamac_slice_accumulator_if.slave    bus,
    output logic                        busy,
    output logic [$clog2(MAX_SLICES)-1:0] cur_slice
);
    import pamac_pkg::*;

    localparam int IDX_W = $clog2(MAX_SLICES);

    pamac_state_t            state_q;
    pamac_state_t            state_d;
    logic                    in_ready_c;
    logic                    accept;
    logic                    last_slice;

    logic signed [WGT_W-1:0] weight_q;
    logic [ACT_W-1:0]        act_q;
    logic [IDX_W-1:0]        nsl_q;
    logic [IDX_W-1:0]        k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_q;
    logic                    valid_q;

    logic signed [2:0]       digit;
    logic signed [ACC_W-1:0] pp;
    logic signed [ACC_W-1:0] acc_next;

    assign last_slice = (k_q == nsl_q);
    assign digit      = digit_of(act_q, k_q, last_slice);
    assign acc_next   = acc_q + pp;
    assign accept     = bus.in_valid && in_ready_c;

    pamac_pp_gen #(
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_pp_gen (
        .weight (weight_q),
        .digit  (digit),
        .k      (k_q),
        .pp     (pp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and in_ready decode; DONE forwards out_ready so a new
    // operand can be taken on the same edge the result is consumed.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    state_d = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, slice counter, accumulator and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_q <= '0;
            act_q    <= '0;
            nsl_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                weight_q <= bus.in_weight;
                act_q    <= bus.in_act;
                nsl_q    <= bus.in_nslices;
                k_q      <= '0;
                acc_q    <= '0;
            end else if (state_q == RUN) begin
                acc_q <= acc_next;
                k_q   <= k_q + 1'b1;
            end

            if (state_q == RUN && last_slice) begin
                sum_q   <= acc_next;
                valid_q <= 1'b1;
            end else if (state_q == DONE && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign busy          = (state_q == RUN);
    assign cur_slice     = k_q;

endmodule

// File: tb/tb_pamac_slice_accumulator.sv
// Scoreboard bench for pamac_slice_accumulator: directed cases followed by
// randomized operands and random back-pressure, checked against an
// arithmetic reference model.
module tb_pamac_slice_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [2:0] cur_slice;

    pamac_slice_accumulator_if bus ();

    pamac_slice_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .cur_slice (cur_slice)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, req);
        end
    endtask

    // Reference: weight times the activation truncated to 2*(n+1) bits and
    // read as two's complement, wrapped to 32 bits.
    function automatic logic [31:0] ref_product(input int w, input logic [15:0] a, input int n);
        longint bits;
        longint m;
        longint v;
        bits = 2 * (n + 1);
        m    = longint'(1) << bits;
        v    = longint'({48'd0, a}) & (m - 1);
        if (v >= m / 2) v = v - m;
        return 32'(longint'(w) * v);
    endfunction

    // Presents one operand pair and pushes its expected result on acceptance.
    // Returns at accept edge + 1 time unit with in_valid dropped.
    task automatic send(input int w, input logic [15:0] a, input int n, input logic [31:0] expv);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.in_weight  = 8'(w);
        bus.in_act     = a;
        bus.in_nslices = 3'(n);
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                exp_q.push_back(expv);
                done = 1'b1;
                #1;
                bus.in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 required 1");
            bus.in_valid = 1'b0;
        end
    endtask

    // Called right after send(): counts edges (accept edge = 1) until out_valid.
    task automatic latency(input string name, input int exp_edges, input int exp_busy);
        int edges;
        int busy_cnt;
        bit seen;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cnt++;
            if (bus.out_valid) seen = 1'b1;
        end
        check({name, "_edges"}, edges, exp_edges);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid got 0 required 1", name);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check({name, "_outstanding"}, exp_q.size(), 0);
    endtask

    // Back-pressure generator.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Result monitor: compares every presented result against the queue head
    // (so held results are checked for stability) and pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid) begin
                check("done_in_ready", bus.in_ready, bus.out_ready);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%08h required no result", bus.out_sum);
                end else begin
                    check("out_sum", bus.out_sum, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit found;
        bus.in_valid   = 1'b0;
        bus.in_weight  = '0;
        bus.in_act     = '0;
        bus.in_nslices = '0;
        bus.out_ready  = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_slice", cur_slice, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-slice op and latency
        send(5, 16'h0007, 1, 32'd35);
        check("t1_cur_slice0", cur_slice, 0);
        latency("t1", 3, 2);
        drain("t1");

        // Full precision, negative top digit
        send(-128, 16'h8000, 7, 32'h0040_0000);
        latency("t2", 9, 8);
        drain("t2");

        // One slice, signed digit; upper bits ignored
        send(127, 16'h0003, 0, 32'hFFFF_FF81);
        wait_valid("t3a");
        drain("t3a");
        send(127, 16'hFFFF, 0, 32'hFFFF_FF81);
        wait_valid("t3b");
        drain("t3b");

        // Held result, then consume and accept together
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(9, 16'h1234, 7, 32'd41940);
        wait_valid("t4");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t4_hold_in_ready", bus.in_ready, 0);
            check("t4_hold_valid", bus.out_valid, 1);
        end
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_weight  = 8'(-3);
        bus.in_act     = 16'h00FF;
        bus.in_nslices = 3'd3;
        bus.in_valid   = 1'b1;
        #1;
        check("t4_in_ready", bus.in_ready, 1);
        @(posedge clk);
        exp_q.push_back(32'd3);
        #1;
        bus.in_valid = 1'b0;
        check("t4_busy", busy, 1);
        check("t4_valid_drop", bus.out_valid, 0);
        check("t4_cur_slice", cur_slice, 0);
        wait_valid("t4b");
        drain("t4");

        // Reset in the middle of a run
        send(7, 16'h5555, 7, ref_product(7, 16'h5555, 7));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (cur_slice == 3'd3) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("t5_reached_slice3", found, 1);
        check("t5_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_in_ready", bus.in_ready, 1);
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_busy_clr", busy, 0);
        check("t5_cur_slice", cur_slice, 0);
        check("t5_out_sum", bus.out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        send(3, 16'h0002, 1, 32'd6);
        wait_valid("t5");
        drain("t5");

        // Random operands with random gaps and back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic signed [7:0] ws;
            logic [15:0]       a;
            int                n;
            ws = 8'($urandom);
            a  = 16'($urandom);
            n  = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            send(int'(ws), a, n, ref_product(int'(ws), a, n));
        end
        drain("random");
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
